reg16_arbiter: RTL

REG16_ARBITER -- requirements
Module: reg16_arbiter

---
 rtl/reg16_arbiter_pkg.sv | 13 +
 rtl/reg16_arbiter_rr_picker.sv | 26 ++
 rtl/register16.sv | 23 ++
 rtl/reg16_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/reg16_arbiter_pkg.sv
// Shared types and default parameters for the round-robin arbitrated 16-bit register.
package reg16_arbiter_pkg;

  localparam int unsigned DefN       = 4;
  localparam int unsigned DefW       = 16;
  localparam int unsigned DefMaxHold = 8;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StOwn  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/reg16_arbiter_rr_picker.sv
// Combinational round-robin search: first set req bit at or after ptr, wrapping modulo N.
module rr_picker #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic            found,
  output logic [IdxW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Walk offsets from farthest to nearest so the nearest hit is the one that sticks.
    for (int k = int'(N) - 1; k >= 0; k--) begin
      int unsigned j;
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        found = 1'b1;
        idx   = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/register16.sv
// Plain W-bit storage register with synchronous active-high reset.
module register16 #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/reg16_arbiter.sv
// N-requester round-robin arbiter owning a shared register; owners may lock for up to MAX_HOLD cycles.
module reg16_arbiter
  import reg16_arbiter_pkg::*;
#(
  parameter int unsigned N        = DefN,
  parameter int unsigned W        = DefW,
  parameter int unsigned MAX_HOLD = DefMaxHold,
  parameter int unsigned IdxW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [N-1:0]   wr_en,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [IdxW-1:0] owner,
  output logic           busy,
  output logic [W-1:0]   q
);

  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_e       state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;

  logic             release_now;
  logic [IdxW-1:0]  next_ptr;
  logic [IdxW-1:0]  pick_ptr;
  logic             pick_found;
  logic [IdxW-1:0]  pick_idx;
  logic             wr_fire;
  logic [W-1:0]     reg_d;

  assign next_ptr    = (owner_q == IdxW'(N - 1)) ? '0 : owner_q + 1'b1;
  assign release_now = (state_q == StOwn) &&
                       (!lock[owner_q] || !req[owner_q] || hold_q == HoldW'(MAX_HOLD - 1));
  // On release the search starts after the owner, so it only wins again when nobody else asks.
  assign pick_ptr    = (state_q == StOwn) ? next_ptr : ptr_q;

  rr_picker #(
    .N    (N),
    .IdxW (IdxW)
  ) u_picker (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (state_q == StIdle || release_now) begin
      if (state_q == StOwn) begin
        ptr_d = next_ptr;
      end
      if (pick_found) begin
        state_d = StOwn;
        gnt_d   = N'(1) << pick_idx;
        owner_d = pick_idx;
        hold_d  = '0;
      end else begin
        state_d = StIdle;
        gnt_d   = '0;
        hold_d  = '0;
      end
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign wr_fire = (state_q == StOwn) && gnt_q[owner_q] && req[owner_q] && wr_en[owner_q];
  assign reg_d   = wr_fire ? wdata[owner_q*W +: W] : q;

  register16 #(
    .W (16)
  ) u_reg (
    .clk   (clk),
    .reset (reset),
    .d     (reg_d),
    .q     (q)
  );

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = (state_q == StOwn);

endmodule
